// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid FIFO toward writeback, architectural
// flag register, and branch-condition evaluation on the committed flags.
module alu_result_stage #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_result,
  input  logic                  in_z,
  input  logic                  in_n,
  input  logic                  in_c,
  input  logic                  in_v,
  input  logic                  in_flag_we,
  input  logic [REG_ADDR_W-1:0] in_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [3:0]            out_flags,
  output logic [3:0]            flags_q,
  input  logic [2:0]            cond_sel,
  output logic                  cond_true
);

  // state | meaning
  // EMPTY | no entry held
  // ONE   | main register M holds the head entry
  // TWO   | M holds the head, skid register S holds the next entry
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]      m_result, s_result;
  logic [REG_ADDR_W-1:0] m_dest, s_dest;
  logic [3:0]            m_flags, s_flags;
  logic [3:0]            in_flags;
  logic                  accept, emit;
  logic                  load_m, load_s, move_s;

  assign in_flags  = {in_n, in_z, in_c, in_v};
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_m  = 1'b0;
    load_s  = 1'b0;
    move_s  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_m  = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && !emit) begin
          load_s  = 1'b1;
          state_d = TWO;
        end else if (accept && emit) begin
          load_m  = 1'b1;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (emit) begin
          move_s  = 1'b1;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_result <= '0;
      m_dest   <= '0;
      m_flags  <= '0;
      s_result <= '0;
      s_dest   <= '0;
      s_flags  <= '0;
    end else begin
      if (load_m) begin
        m_result <= in_result;
        m_dest   <= in_dest;
        m_flags  <= in_flags;
      end else if (move_s) begin
        m_result <= s_result;
        m_dest   <= s_dest;
        m_flags  <= s_flags;
      end
      if (load_s) begin
        s_result <= in_result;
        s_dest   <= in_dest;
        s_flags  <= in_flags;
      end
    end
  end

  // Flags commit at accept time so branches see issue order, not writeback order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      flags_q <= 4'b0000;
    else if (accept && in_flag_we) flags_q <= in_flags;
  end

  assign out_result = m_result;
  assign out_dest   = m_dest;
  assign out_flags  = m_flags;

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = flags_q[2];
      3'd2:    cond_true = ~flags_q[2];
      3'd3:    cond_true = flags_q[3];
      3'd4:    cond_true = ~flags_q[3];
      3'd5:    cond_true = flags_q[1];
      3'd6:    cond_true = flags_q[0];
      default: cond_true = 1'b0;
    endcase
  end

endmodule
